// File: rtl/vram_scan_arbiter.sv
// Shares one single-port frame-buffer RAM between VGA scan-out and a host req/ack port.
// Video fetches always win the RAM cycle; host transactions retry on the next free clock.
module vram_scan_arbiter #(
  parameter int         CANVAS_W   = 28,
  parameter int         CANVAS_H   = 28,
  parameter int         SCALE_LOG2 = 4,
  parameter int         X0         = 96,
  parameter int         Y0         = 16,
  parameter int         AW         = 10,
  parameter logic [7:0] BG_COLOR   = 8'h49
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic [7:0]    rgb,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [7:0]    host_wdata,
  output logic          host_ack,
  output logic [7:0]    host_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata
);

  localparam logic [9:0] CV_W_PX = 10'(CANVAS_W << SCALE_LOG2);
  localparam logic [9:0] CV_H_PX = 10'(CANVAS_H << SCALE_LOG2);

  typedef enum logic [2:0] {IDLE, HWR, HRD, HRD_CAP, ACK} state_t;

  state_t        state_q, state_d;
  logic [9:0]    dx, dy, cellX, cellY;
  logic          inCv, videoFetch, grant, capture;
  logic [AW-1:0] vaddr, addr_q;
  logic [7:0]    wdata_q, rdata_q, rgb_q, rgb_d;
  logic          tick_q, hit_q, vis_q;

  // Unsigned subtraction makes coordinates left of / above the canvas wrap to large values.
  assign dx         = x - 10'(X0);
  assign dy         = y - 10'(Y0);
  assign cellX      = dx >> SCALE_LOG2;
  assign cellY      = dy >> SCALE_LOG2;
  assign inCv       = (dx < CV_W_PX) && (dy < CV_H_PX);
  assign vaddr      = AW'(32'(cellY) * CANVAS_W + 32'(cellX));
  assign videoFetch = p_tick & video_on & inCv;

  always_comb begin
    rgb_d = rgb_q;
    if (tick_q) begin
      if (hit_q)      rgb_d = ram_rdata;
      else if (vis_q) rgb_d = BG_COLOR;
      else            rgb_d = 8'h00;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    capture   = 1'b0;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (videoFetch) ram_addr = vaddr;
    case (state_q)
      IDLE: begin
        if (host_req && !videoFetch) begin
          grant   = 1'b1;
          state_d = host_we ? HWR : HRD;
        end
      end
      HWR: begin
        if (!videoFetch) begin
          ram_addr  = addr_q;
          ram_we    = 1'b1;
          ram_wdata = wdata_q;
          state_d   = ACK;
        end
      end
      HRD: begin
        if (!videoFetch) begin
          ram_addr = addr_q;
          state_d  = HRD_CAP;
        end
      end
      HRD_CAP: begin
        capture = 1'b1;
        state_d = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any host transaction in flight, so no ack is ever issued for it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      rgb_q   <= 8'h00;
      tick_q  <= 1'b0;
      hit_q   <= 1'b0;
      vis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= p_tick;
      hit_q   <= videoFetch;
      vis_q   <= video_on;
      rgb_q   <= rgb_d;
      if (grant) begin
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
      end
      if (capture) rdata_q <= ram_rdata;
    end
  end

  assign rgb        = rgb_q;
  assign host_rdata = rdata_q;
  assign host_ack   = (state_q == ACK);

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Self-checking bench for vram_scan_arbiter: synchronous RAM model plus scoreboard
// queues holding the expected host acks and pixel outputs.
module tb_vram_scan_arbiter;

  localparam int         X0 = 96;
  localparam int         Y0 = 16;
  localparam int         AW = 10;
  localparam logic [7:0] BG = 8'h49;

  typedef struct { int due; logic [7:0] rdata; } ackExp_t;
  typedef struct { int due; logic [7:0] val; logic [7:0] prev; } rgbExp_t;
  typedef struct { logic [9:0] px; logic [9:0] py; logic vis; logic [AW-1:0] addr; logic [7:0] val; } pix_t;
  typedef struct { logic we; logic [AW-1:0] addr; logic [7:0] wdata; int lat; logic [7:0] rdata; } hostOp_t;
  typedef struct { int pixAt; pix_t pix; hostOp_t op; } preempt_t;

  logic          clk;
  logic          reset;
  logic          p_tick;
  logic          video_on;
  logic [9:0]    x;
  logic [9:0]    y;
  logic [7:0]    rgb;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;
  logic [7:0]    host_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  logic [7:0] mem [0:1023];

  int         testsRun    = 0;
  int         testsFailed = 0;
  int         cyc         = 0;
  int         t0;
  logic       got;
  logic [7:0] lastRgb     = 8'h00;
  ackExp_t    ackQ[$];
  rgbExp_t    rgbQ[$];
  ackExp_t    e;
  rgbExp_t    r;

  vram_scan_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .p_tick     (p_tick),
    .video_on   (video_on),
    .x          (x),
    .y          (y),
    .rgb        (rgb),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_ack   (host_ack),
    .host_rdata (host_rdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, read data one clock after the address.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic startHost(input hostOp_t op);
    step();
    host_req   = 1'b1;
    host_we    = op.we;
    host_addr  = op.addr;
    host_wdata = op.wdata;
    ackQ.push_back('{due: cyc + op.lat, rdata: op.rdata});
  endtask

  task automatic applyStimulus(input pix_t p);
    p_tick   = 1'b1;
    video_on = p.vis;
    x        = p.px;
    y        = p.py;
    rgbQ.push_back('{due: cyc + 2, val: p.val, prev: lastRgb});
    lastRgb = p.val;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; p_tick = 1'b0; video_on = 1'b0; x = '0; y = '0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 10'd3; host_wdata = 8'h11;
    repeat (3) step();
    testsRun++;
    if (rgb !== 8'h00 || host_ack !== 1'b0 || ram_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset outputs: rgb %h ack %b we %b, required 00 0 0", rgb, host_ack, ram_we);
    end
    testsRun++;
    if (host_rdata !== 8'h00 || ram_addr !== '0 || ram_wdata !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL reset regs: rdata %h addr %0d wdata %h, required 00 0 00", host_rdata, ram_addr, ram_wdata);
    end
    reset = 1'b0; t0 = cyc; got = 1'b0;
    ackQ.push_back('{due: cyc + 2, rdata: 8'h00});
    for (int i = 0; i < 8 && !got; i++) begin
      step(); #1;
      if (cyc == t0 + 1) begin
        testsRun++;
        if (ram_we !== 1'b1 || ram_addr !== 10'd3 || ram_wdata !== 8'h11) begin
          testsFailed++;
          $display("[TB] FAIL post-reset write: we %b addr %0d data %h, required 1 3 11", ram_we, ram_addr, ram_wdata);
        end
      end
      if (host_ack) begin
        got = 1'b1; host_req = 1'b0; e = ackQ.pop_front(); testsRun++;
        if (cyc !== e.due || host_rdata !== e.rdata) begin
          testsFailed++;
          $display("[TB] FAIL post-reset ack: cycle %0d rdata %h, required %0d %h", cyc, host_rdata, e.due, e.rdata);
        end
      end
    end
    if (!got) begin
      testsRun++; testsFailed++; ackQ.delete(); host_req = 1'b0;
      $display("[TB] FAIL post-reset ack: no ack, required one at cycle %0d", t0 + 2);
    end
  endtask

  task automatic test_write_read();
    hostOp_t ops[4] = '{'{1'b1, 10'd0,    8'hE0, 2, 8'h00},
                        '{1'b0, 10'd0,    8'h00, 3, 8'hE0},
                        '{1'b1, 10'd1000, 8'h77, 2, 8'hE0},
                        '{1'b0, 10'd1000, 8'h00, 3, 8'h77}};
    foreach (ops[k]) begin
      startHost(ops[k]); t0 = cyc; got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
        step(); #1;
        if (cyc == t0 + 1) begin
          testsRun++;
          if (ram_we !== ops[k].we || ram_addr !== ops[k].addr || (ops[k].we && ram_wdata !== ops[k].wdata)) begin
            testsFailed++;
            $display("[TB] FAIL host drive op%0d: we %b addr %0d data %h, required %b %0d %h",
                     k, ram_we, ram_addr, ram_wdata, ops[k].we, ops[k].addr, ops[k].wdata);
          end
        end
        if (host_ack) begin
          got = 1'b1; host_req = 1'b0; e = ackQ.pop_front(); testsRun++;
          if (cyc !== e.due || host_rdata !== e.rdata) begin
            testsFailed++;
            $display("[TB] FAIL host ack op%0d: cycle %0d rdata %h, required %0d %h", k, cyc, host_rdata, e.due, e.rdata);
          end
        end
      end
      if (!got) begin
        testsRun++; testsFailed++; ackQ.delete(); host_req = 1'b0;
        $display("[TB] FAIL host ack op%0d: no ack, required one at cycle %0d", k, t0 + ops[k].lat);
      end
    end
  endtask

  task automatic test_video_fetch();
    int   fillErr = 0;
    pix_t pix[4] = '{'{10'(X0 + 16),  10'(Y0 + 32),  1'b1, 10'd57,  8'h39},
                     '{10'(X0),       10'(Y0),       1'b1, 10'd0,   8'h00},
                     '{10'(X0 + 447), 10'(Y0 + 447), 1'b1, 10'd783, 8'h0F},
                     '{10'(X0 + 100), 10'(Y0 + 200), 1'b1, 10'd342, 8'h56}};
    for (int a = 0; a < 784; a++) begin
      step();
      host_req = 1'b1; host_we = 1'b1; host_addr = AW'(a); host_wdata = 8'(a);
      got = 1'b0;
      for (int i = 0; i < 6 && !got; i++) begin
        step();
        if (host_ack) begin got = 1'b1; host_req = 1'b0; end
      end
      if (!got) begin fillErr++; host_req = 1'b0; end
    end
    testsRun++;
    if (fillErr != 0) begin
      testsFailed++;
      $display("[TB] FAIL fill acks: %0d writes unacked, required 0", fillErr);
    end
    foreach (pix[k]) begin
      step();
      applyStimulus(pix[k]);
      testsRun++;
      if (ram_addr !== pix[k].addr || ram_we !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL video addr pix%0d: addr %0d we %b, required %0d 0", k, ram_addr, ram_we, pix[k].addr);
      end
      for (int i = 0; i < 3; i++) begin
        step(); p_tick = 1'b0;
        if (rgbQ.size() > 0 && cyc == rgbQ[0].due - 1) begin
          testsRun++;
          if (rgb !== rgbQ[0].prev) begin
            testsFailed++;
            $display("[TB] FAIL rgb early pix%0d: rgb %h, required %h", k, rgb, rgbQ[0].prev);
          end
        end
        if (rgbQ.size() > 0 && cyc == rgbQ[0].due) begin
          r = rgbQ.pop_front(); testsRun++;
          if (rgb !== r.val) begin
            testsFailed++;
            $display("[TB] FAIL rgb pix%0d: rgb %h, required %h", k, rgb, r.val);
          end
        end
      end
    end
  endtask

  task automatic test_outside_canvas();
    pix_t pix[7] = '{'{10'(X0 - 1),   10'(Y0 + 32),  1'b1, 10'd0,   BG},
                     '{10'(X0 + 447), 10'(Y0 + 32),  1'b1, 10'd83,  8'h53},
                     '{10'(X0 + 448), 10'(Y0 + 32),  1'b1, 10'd0,   BG},
                     '{10'(X0 + 16),  10'(Y0 + 447), 1'b1, 10'd757, 8'hF5},
                     '{10'(X0 + 16),  10'(Y0 + 448), 1'b1, 10'd0,   BG},
                     '{10'(X0 + 16),  10'(Y0 - 1),   1'b1, 10'd0,   BG},
                     '{10'(X0 - 1),   10'(Y0 + 32),  1'b0, 10'd0,   8'h00}};
    foreach (pix[k]) begin
      step();
      applyStimulus(pix[k]);
      testsRun++;
      if (ram_addr !== pix[k].addr || ram_we !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL edge addr pix%0d: addr %0d we %b, required %0d 0", k, ram_addr, ram_we, pix[k].addr);
      end
      for (int i = 0; i < 3; i++) begin
        step(); p_tick = 1'b0;
        if (rgbQ.size() > 0 && cyc == rgbQ[0].due - 1) begin
          testsRun++;
          if (rgb !== rgbQ[0].prev) begin
            testsFailed++;
            $display("[TB] FAIL edge rgb early pix%0d: rgb %h, required %h", k, rgb, rgbQ[0].prev);
          end
        end
        if (rgbQ.size() > 0 && cyc == rgbQ[0].due) begin
          r = rgbQ.pop_front(); testsRun++;
          if (rgb !== r.val) begin
            testsFailed++;
            $display("[TB] FAIL edge rgb pix%0d: rgb %h, required %h", k, rgb, r.val);
          end
        end
      end
    end
  endtask

  task automatic test_preempt();
    preempt_t sc[3] = '{'{0, '{10'(X0 + 16),  10'(Y0 + 32),  1'b1, 10'd57,  8'h39}, '{1'b1, 10'd5, 8'hA5, 3, 8'h77}},
                        '{1, '{10'(X0 + 100), 10'(Y0 + 200), 1'b1, 10'd342, 8'h56}, '{1'b1, 10'd6, 8'h5A, 3, 8'h77}},
                        '{1, '{10'(X0 + 447), 10'(Y0 + 447), 1'b1, 10'd783, 8'h0F}, '{1'b0, 10'd5, 8'h00, 4, 8'hA5}}};
    foreach (sc[k]) begin
      startHost(sc[k].op); t0 = cyc; got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        if (cyc == t0 + sc[k].pixAt) begin
          applyStimulus(sc[k].pix);
          testsRun++;
          if (ram_addr !== sc[k].pix.addr || ram_we !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL video priority sc%0d: addr %0d we %b, required %0d 0", k, ram_addr, ram_we, sc[k].pix.addr);
          end
        end
        step(); p_tick = 1'b0; #1;
        if (rgbQ.size() > 0 && cyc == rgbQ[0].due - 1) begin
          testsRun++;
          if (rgb !== rgbQ[0].prev) begin
            testsFailed++;
            $display("[TB] FAIL preempt rgb early sc%0d: rgb %h, required %h", k, rgb, rgbQ[0].prev);
          end
        end
        if (rgbQ.size() > 0 && cyc == rgbQ[0].due) begin
          r = rgbQ.pop_front(); testsRun++;
          if (rgb !== r.val) begin
            testsFailed++;
            $display("[TB] FAIL preempt rgb sc%0d: rgb %h, required %h", k, rgb, r.val);
          end
        end
        if (cyc == t0 + 2) begin
          testsRun++;
          if (ram_we !== sc[k].op.we || ram_addr !== sc[k].op.addr || (sc[k].op.we && ram_wdata !== sc[k].op.wdata)) begin
            testsFailed++;
            $display("[TB] FAIL deferred host sc%0d: we %b addr %0d data %h, required %b %0d %h",
                     k, ram_we, ram_addr, ram_wdata, sc[k].op.we, sc[k].op.addr, sc[k].op.wdata);
          end
        end
        if (host_ack) begin
          got = 1'b1; host_req = 1'b0; e = ackQ.pop_front(); testsRun++;
          if (cyc !== e.due || host_rdata !== e.rdata) begin
            testsFailed++;
            $display("[TB] FAIL preempt ack sc%0d: cycle %0d rdata %h, required %0d %h", k, cyc, host_rdata, e.due, e.rdata);
          end
        end
      end
      if (!got) begin
        testsRun++; testsFailed++; ackQ.delete(); host_req = 1'b0;
        $display("[TB] FAIL preempt ack sc%0d: no ack, required one at cycle %0d", k, t0 + sc[k].op.lat);
      end
      rgbQ.delete();
    end
  endtask

  task automatic test_reset_mid();
    logic acked = 1'b0;
    startHost('{1'b0, 10'd57, 8'h00, 3, 8'h00});
    step(); step();
    #1 reset = 1'b1;
    ackQ.delete();
    #1;
    testsRun++;
    if (host_ack !== 1'b0 || ram_we !== 1'b0 || host_rdata !== 8'h00 || rgb !== 8'h00) begin
      testsFailed++;
      $display("[TB] FAIL mid reset: ack %b we %b rdata %h rgb %h, required 0 0 00 00", host_ack, ram_we, host_rdata, rgb);
    end
    host_req = 1'b0;
    repeat (3) begin
      step();
      if (host_ack) acked = 1'b1;
    end
    testsRun++;
    if (acked !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL discarded read: ack seen %b, required 0", acked);
    end
    reset = 1'b0; lastRgb = 8'h00;
    startHost('{1'b0, 10'd57, 8'h00, 3, 8'h39}); t0 = cyc; got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (host_ack) begin
        got = 1'b1; host_req = 1'b0; e = ackQ.pop_front(); testsRun++;
        if (cyc !== e.due || host_rdata !== e.rdata) begin
          testsFailed++;
          $display("[TB] FAIL reissued read: cycle %0d rdata %h, required %0d %h", cyc, host_rdata, e.due, e.rdata);
        end
      end
    end
    if (!got) begin
      testsRun++; testsFailed++; ackQ.delete(); host_req = 1'b0;
      $display("[TB] FAIL reissued read: no ack, required one at cycle %0d", t0 + 3);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_video_fetch();
    test_outside_canvas();
    test_preempt();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: run did not complete, %0d tests run so far", testsRun);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
